// File: rtl/usb_rx_decoder.sv
// USB receive front end: resynchronising bit clock, NRZI decode, bit unstuffing,
// and SYNC / byte / EOP framing with a sticky per-packet error flag.
module usb_rx_decoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rcving,
    output logic       eop,
    output logic       rx_error
);
    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] PHASE_MAX = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_MID = PW'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_WAIT,
        ST_ERR_WAIT
    } state_t;

    state_t        state_q;
    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;
    logic          dp_last_q;
    logic          prev_dp_q;
    logic [2:0]    ones_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          se0_seen_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q;
    logic          rcving_q;
    logic          eop_q;
    logic          rx_error_q;

    logic          line_j_s;
    logic          line_k_s;
    logic          line_se0_s;
    logic          strobe_s;
    logic          bit_s;
    logic [7:0]    byte_s;

    // Line decode, mid-bit strobe, NRZI bit and phase counter next value
    always_comb begin
        line_j_s   = d_plus;
        line_k_s   = ~d_plus & d_minus;
        line_se0_s = ~d_plus & ~d_minus;
        strobe_s   = (phase_q == PHASE_MID);
        bit_s      = (d_plus == prev_dp_q);
        byte_s     = {bit_s, shift_q[7:1]};
        if ((d_plus != dp_last_q) || ((state_q == ST_IDLE) && line_k_s)) begin
            phase_d = '0;
        end else if (phase_q == PHASE_MAX) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PW'(1);
        end
    end

    // Receive state machine with all datapath registers and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            dp_last_q  <= 1'b1;
            prev_dp_q  <= 1'b1;
            ones_q     <= 3'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            se0_seen_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rcving_q   <= 1'b0;
            eop_q      <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            dp_last_q  <= d_plus;
            rx_valid_q <= 1'b0;
            eop_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    prev_dp_q  <= 1'b1;
                    ones_q     <= 3'd0;
                    bit_cnt_q  <= 3'd0;
                    se0_seen_q <= 1'b0;
                    if (line_k_s) begin
                        state_q    <= ST_SYNC;
                        rx_error_q <= 1'b0;
                        rcving_q   <= 1'b1;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    if (strobe_s) begin
                        prev_dp_q <= d_plus;
                        if (line_se0_s) begin
                            state_q <= ST_EOP_WAIT;
                            if ((state_q == ST_SYNC) || (bit_cnt_q != 3'd0)) begin
                                rx_error_q <= 1'b1;
                            end
                        end else if ((ones_q == 3'd6) && bit_s) begin
                            state_q    <= ST_ERR_WAIT;
                            rx_error_q <= 1'b1;
                        end else if (ones_q == 3'd6) begin
                            // stuffed zero: drop it, it carries no data
                            ones_q <= 3'd0;
                        end else begin
                            ones_q    <= bit_s ? (ones_q + 3'd1) : 3'd0;
                            shift_q   <= byte_s;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == ST_DATA) begin
                                    rx_data_q  <= byte_s;
                                    rx_valid_q <= 1'b1;
                                end else if (byte_s == 8'h80) begin
                                    state_q <= ST_DATA;
                                end else begin
                                    state_q    <= ST_ERR_WAIT;
                                    rx_error_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_EOP_WAIT: begin
                    if (strobe_s && !line_se0_s) begin
                        if (line_k_s) begin
                            state_q    <= ST_ERR_WAIT;
                            rx_error_q <= 1'b1;
                        end else begin
                            state_q  <= ST_IDLE;
                            rcving_q <= 1'b0;
                            eop_q    <= ~rx_error_q;
                        end
                    end
                end
                ST_ERR_WAIT: begin
                    if (strobe_s) begin
                        if (line_se0_s) begin
                            se0_seen_q <= 1'b1;
                        end else if (se0_seen_q && line_j_s) begin
                            state_q  <= ST_IDLE;
                            rcving_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    rcving_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = rx_valid_q;
    assign rcving        = rcving_q;
    assign eop           = eop_q;
    assign rx_error      = rx_error_q;

endmodule
